// File: rtl/elementwise_operand_streamer.sv
// elementwise_operand_streamer
// Streams one (unary op) or two (binary op) tensors out of buffer SRAM as
// aligned operand streams for the element-wise unit. A small FSM walks the
// read addresses, the read strobes are decoded combinationally from state,
// and the valid flags are the strobes delayed by the fixed SRAM latency.

module elementwise_operand_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            op_type,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  stall,
  output logic                  rd_en_a,
  output logic                  rd_en_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  ew_enable,
  output logic [2:0]            ew_op_type,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  issued
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [2:0]            OP_ABS   = 3'b101;
  localparam logic [2:0]            OP_NEG   = 3'b110;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = LEN_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

  // Unary ops consume only tensor A.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_ABS) || (op == OP_NEG);
  endfunction

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    issued_q, issued_d;
  logic                    valid_a_q;
  logic                    valid_b_q;

  logic                    start_acc_s;
  logic                    rd_a_s;
  logic                    rd_b_s;
  logic                    last_rd_s;
  logic                    unary_s;

  assign unary_s     = is_unary(op_q);
  assign start_acc_s = (state_q == S_IDLE) && start;
  // Abort outranks stall; both only matter while streaming.
  assign rd_a_s      = (state_q == S_STREAM) && !stall && !abort && (issued_q < len_q);
  assign rd_b_s      = rd_a_s && !unary_s;
  assign last_rd_s   = rd_a_s && ((issued_q + LEN_ONE) == len_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero-length jobs skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (length == LEN_ZERO) ? S_DONE : S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_rd_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job configuration and address walk: load on accepted start, step per read.
  always_comb begin
    op_d     = op_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    len_d    = len_q;
    issued_d = issued_q;
    if (start_acc_s) begin
      op_d     = op_type;
      addr_a_d = base_a;
      addr_b_d = is_unary(op_type) ? ADDR_ZERO : base_b;
      len_d    = length;
      issued_d = LEN_ZERO;
    end else if (rd_a_s) begin
      addr_a_d = addr_a_q + ADDR_ONE;
      addr_b_d = unary_s ? ADDR_ZERO : (addr_b_q + ADDR_ONE);
      issued_d = issued_q + LEN_ONE;
    end else begin
      issued_d = issued_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'b000;
      addr_a_q <= ADDR_ZERO;
      addr_b_q <= ADDR_ZERO;
      len_q    <= LEN_ZERO;
      issued_q <= LEN_ZERO;
    end else begin
      op_q     <= op_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      len_q    <= len_d;
      issued_q <= issued_d;
    end
  end

  // Valid flags track the one-cycle SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      valid_a_q <= rd_a_s;
      valid_b_q <= rd_b_s;
    end
  end

  // Output decode from state and registers.
  always_comb begin
    rd_en_a    = rd_a_s;
    rd_en_b    = rd_b_s;
    rd_addr_a  = addr_a_q;
    rd_addr_b  = addr_b_q;
    valid_a    = valid_a_q;
    valid_b    = valid_b_q;
    data_a     = rd_data_a;
    data_b     = rd_data_b;
    ew_op_type = op_q;
    issued     = issued_q;
    ew_enable  = (state_q == S_STREAM) || (state_q == S_DRAIN);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

endmodule

// File: doc/elementwise_operand_streamer.md
# elementwise_operand_streamer

Front-end sequencer for the element-wise operations unit. It streams one tensor (unary ops) or two tensors (binary ops) out of on-chip buffer SRAM and presents them as aligned `valid_a/data_a` and `valid_b/data_b` operand streams. It also drives the unit's `enable` and `op_type` for the whole job and pulses `done` in the same cycle as the unit's last registered result. It sits between the buffer SRAM read ports and the element-wise unit's operand inputs, and is programmed by the layer controller.

## Interface
- `DATA_WIDTH`, 8, operand width; identical to the element-wise unit.
- `ADDR_WIDTH`, 16, SRAM word address width.
- `LEN_WIDTH`, 16, element-count width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job launch pulse; sampled only in IDLE.
- `abort`  in  1  cancels the job in progress.
- `op_type`  in  3  op code; latched at start. ADD=000, SUB=001, MUL=010, MAX=011, MIN=100, ABS=101, NEG=110.
- `base_a`  in  ADDR_WIDTH  tensor A start address; latched at start.
- `base_b`  in  ADDR_WIDTH  tensor B start address; latched at start.
- `length`  in  LEN_WIDTH  element count; latched at start.
- `stall`  in  1  downstream back-pressure; suppresses new reads.
- `rd_en_a` / `rd_en_b`  out  1  SRAM read strobes.
- `rd_addr_a` / `rd_addr_b`  out  ADDR_WIDTH  SRAM read addresses.
- `rd_data_a` / `rd_data_b`  in  DATA_WIDTH  SRAM read data; fixed 1-cycle read latency.
- `ew_enable`  out  1  to the element-wise unit `enable`.
- `ew_op_type`  out  3  to the element-wise unit `op_type`.
- `valid_a` / `valid_b`  out  1  operand valid flags.
- `data_a` / `data_b`  out  DATA_WIDTH  operand data, signed.
- `busy`  out  1  high in STREAM, DRAIN and DONE.
- `done`  out  1  single-cycle completion pulse.
- `issued`  out  LEN_WIDTH  reads issued so far in the current job.

## Operation
- FSM states:
  - IDLE
    - `start` with `length` not 0 -> STREAM.
    - `start` with `length` = 0 -> DONE, with no reads issued.
  - STREAM
    - Each cycle with `!stall && !abort`: assert `rd_en_a`, and also `rd_en_b` for binary ops.
    - On each such read, the address registers and `issued` increment by 1.
    - Issuing read number `length` -> DRAIN.
  - DRAIN: lasts one cycle while the last read data returns -> DONE.
  - DONE: `done`=1 for one cycle -> IDLE.
- Read strobes are combinational from state, `stall`, `abort` and `issued`. Addresses come straight from the address registers.
- Addresses wrap modulo 2^ADDR_WIDTH with no error flag.
- Unary ops (ABS, NEG):
  - `rd_en_b`, `valid_b` and `rd_addr_b` are held at 0.
  - `base_b` is ignored.
- `valid_a` is `rd_en_a` delayed by one flop. `valid_b` is `rd_en_b` delayed by one flop.
- `data_a` = `rd_data_a` and `data_b` = `rd_data_b`, passed through combinationally. This keeps each valid aligned with its data.
- `ew_enable` is 1 in STREAM and DRAIN and 0 otherwise. `ew_op_type` is the latched op code, held after the job ends.
- `stall` gaps:
  - `stall` has effect only in STREAM.
  - A read issued in the cycle before `stall` rises still produces its valid beat.
  - `ew_enable` stays high through stall gaps. The unit then registers `valid_out`=0 for those beats.
- `start` while `busy` is ignored. Config registers change only on an accepted `start`.
- `abort` in STREAM or DRAIN:
  - No read is issued that cycle, and the FSM goes to IDLE next cycle.
  - No `done` pulse; `issued` keeps its value.
  - In-flight valid beats still appear one cycle later.
- `abort` in IDLE or DONE has no effect.
- `stall` and `abort` together: `abort` wins.

## Timing
- All registered outputs reset to 0, including valid flags, state (IDLE), addresses, `issued` and `ew_op_type`. All combinational strobes evaluate to 0 in reset.
- Reset mid-job returns to IDLE immediately. No `done` pulse.
- Start cycle t0 (IDLE, `start`=1): the first `rd_en` is in cycle t0+1.
- Read-to-operand latency: `rd_en` in cycle t gives `valid`/`data` in cycle t+1. The element-wise unit's `valid_out` follows in cycle t+2.
- With no stalls, the job takes `length`+3 cycles from `start` to the end of `done`. The last read is in t0+`length`.
- Job sequence with the last read at cycle t:
  - DRAIN is cycle t+1.
  - DONE / `done` is cycle t+2. This coincides with the unit's last `valid_out`.
  - IDLE is cycle t+3.
- A new `start` is accepted in the first IDLE cycle after DONE.
- Throughput: one element per cycle when not stalled.

## Test plan
- ADD job: `base_a`=0x0010, `base_b`=0x0100, `length`=4, no stall.
  - `rd_en` in cycles 1-4 with addresses 0x10-0x13 and 0x100-0x103.
  - `valid_a`=`valid_b`=1 in cycles 2-5.
  - `done` in cycle 6; `issued`=4.
- ABS job: `length`=3.
  - `rd_en_b`, `valid_b` and `rd_addr_b` stay 0 throughout.
  - `valid_a` three beats; `done` in cycle 5.
- Stall: `length`=5 with `stall` high for cycles 2-3.
  - Reads are issued in cycles 1, 4, 5, 6, 7.
  - `valid_a` beat present in cycle 2, absent in cycles 3-4.
  - `done` in cycle 9.
- Boundaries:
  - `length`=0: `done` in cycle 1, no `rd_en`.
  - `base_a`=0xFFFE with `length`=4: addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Abort and reset:
  - `abort` in the cycle of the 3rd read of a `length`=8 job: that read is suppressed, IDLE next cycle, no `done`, `issued`=2.
  - `start` pulsed while busy is ignored.
  - `rst_n` low mid-job: all outputs go to 0 immediately.
